// File: rtl/step_updown_counter.sv
// step_updown_counter: parametrised up/down counter that moves by a fixed STEP
// inside [MIN_VAL, MAX_VAL], with synchronous load, count enable, a
// combinational terminal-count flag and a registered wrap pulse.
// Optional feature: define STEP_CNT_SATURATE_EN to hold at the bounds
// instead of wrapping around (wrap then pulses for every held edge).
module step_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int STEP    = 2,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 14
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // One extra bit of headroom so count+STEP never overflows and
    // count-STEP shows its borrow in the top bit.
    localparam int W1 = WIDTH + 1;

    localparam logic [WIDTH:0]   STEP_X = W1'(STEP);
    localparam logic [WIDTH:0]   MIN_X  = W1'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_X  = W1'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_N  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MAX_VAL);

`ifdef STEP_CNT_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    // Reject ranges the stepping logic cannot represent.
    if (MAX_VAL <= MIN_VAL || MAX_VAL > (2 ** WIDTH) - 1 ||
        ((MAX_VAL - MIN_VAL) % STEP) != 0) begin : g_bad_params
        $error("step_updown_counter: illegal WIDTH/STEP/MIN_VAL/MAX_VAL combination");
    end

    logic [WIDTH:0]   lv_x;
    logic [WIDTH:0]   offset;
    logic [WIDTH-1:0] norm_val;
    logic [WIDTH:0]   count_x;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH:0]   diff_dn;
    logic             over_max;
    logic             under_min;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;

    // Clamp the load value into range and snap it down onto the STEP grid.
    always_comb begin
        lv_x   = {1'b0, load_val};
        offset = lv_x - MIN_X;
        if (lv_x < MIN_X) begin
            norm_val = MIN_N;
        end else if (lv_x > MAX_X) begin
            norm_val = MAX_N;
        end else begin
            norm_val = WIDTH'(MIN_X + (offset / STEP_X) * STEP_X);
        end
    end

    // Next count and wrap flag; priority is load, then enabled step, then hold.
    always_comb begin
        count_x    = {1'b0, count};
        sum_up     = count_x + STEP_X;
        diff_dn    = count_x - STEP_X;
        over_max   = (sum_up > MAX_X);
        under_min  = diff_dn[WIDTH] | (diff_dn[WIDTH-1:0] < MIN_N);
        next_count = count;
        next_wrap  = 1'b0;
        if (load) begin
            next_count = norm_val;
        end else if (en) begin
            if (up) begin
                if (over_max) begin
                    next_count = SATURATE ? count : MIN_N;
                    next_wrap  = 1'b1;
                end else begin
                    next_count = WIDTH'(sum_up);
                end
            end else begin
                if (under_min) begin
                    next_count = SATURATE ? count : MAX_N;
                    next_wrap  = 1'b1;
                end else begin
                    next_count = WIDTH'(diff_dn);
                end
            end
        end
    end

    // State register with asynchronous clear to the bottom of the range.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= MIN_N;
            wrap  <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= next_wrap;
        end
    end

    // Terminal count: an enabled step in the current direction would hit the bound.
    assign tc = ~reset & en & ~load &
                ((up & (count == MAX_N)) | (~up & (count == MIN_N)));

endmodule

// File: tb/tb_step_updown_counter.sv
// tb_step_updown_counter: directed, table-driven bench for step_updown_counter
// (default 4-bit/STEP=2/0..14 instance plus a STEP=3/3..15 instance).
module tb_step_updown_counter;

`ifdef STEP_CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tc;
    logic       wrap;

    logic       en3;
    logic       up3;
    logic       load3;
    logic [3:0] load_val3;
    logic [3:0] count3;
    logic       tc3;
    logic       wrap3;

    int checks_total;
    int checks_passed;

    typedef struct {
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] load_val;
        logic       exp_tc;
        logic [3:0] exp_count;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    step_updown_counter #(
        .WIDTH(4), .STEP(2), .MIN_VAL(0), .MAX_VAL(14)
    ) dut (
        .clock(clock), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .wrap(wrap)
    );

    step_updown_counter #(
        .WIDTH(4), .STEP(3), .MIN_VAL(3), .MAX_VAL(15)
    ) dut3 (
        .clock(clock), .reset(reset), .en(en3), .up(up3), .load(load3),
        .load_val(load_val3), .count(count3), .tc(tc3), .wrap(wrap3)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic addVec(input logic e, input logic u, input logic l, input logic [3:0] lv,
                          input logic t, input logic [3:0] c, input logic w);
        vec_t v;
        v.en = e; v.up = u; v.load = l; v.load_val = lv;
        v.exp_tc = t; v.exp_count = c; v.exp_wrap = w;
        vecs.push_back(v);
    endtask

    // Drive at the falling edge, check tc combinationally, then count/wrap after the rising edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clock);
        en = v.en; up = v.up; load = v.load; load_val = v.load_val;
        #1;
        checkOutput($sformatf("vec%0d_tc", idx), 32'(tc), 32'(v.exp_tc));
        @(posedge clock);
        #1;
        checkOutput($sformatf("vec%0d_count", idx), 32'(count), 32'(v.exp_count));
        checkOutput($sformatf("vec%0d_wrap", idx), 32'(wrap), 32'(v.exp_wrap));
    endtask

    task automatic step3(input logic e, input logic u, input logic l, input logic [3:0] lv,
                         input logic exp_tc, input logic [3:0] exp_count, input logic exp_wrap,
                         input string name);
        @(negedge clock);
        en3 = e; up3 = u; load3 = l; load_val3 = lv;
        #1;
        checkOutput({name, "_tc"}, 32'(tc3), 32'(exp_tc));
        @(posedge clock);
        #1;
        checkOutput({name, "_count"}, 32'(count3), 32'(exp_count));
        checkOutput({name, "_wrap"}, 32'(wrap3), 32'(exp_wrap));
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset = 1'b1;
        en = 1'b1; up = 1'b0; load = 1'b0; load_val = 4'd0;
        en3 = 1'b0; up3 = 1'b0; load3 = 1'b0; load_val3 = 4'd0;

        // Up from 0 through the top bound and one step past it.
        for (int i = 0; i < 7; i++) begin
            addVec(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'(2 * i + 2), 1'b0);
        end
        addVec(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, SAT ? 4'd14 : 4'd0, 1'b1);
        addVec(1'b1, 1'b1, 1'b0, 4'd0, SAT, SAT ? 4'd14 : 4'd2, SAT);
        // Back to 0, then down through the bottom bound.
        addVec(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        addVec(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, SAT ? 4'd0 : 4'd14, 1'b1);
        addVec(1'b1, 1'b0, 1'b0, 4'd0, SAT, SAT ? 4'd0 : 4'd12, SAT);
        addVec(1'b1, 1'b0, 1'b0, 4'd0, SAT, SAT ? 4'd0 : 4'd10, SAT);
        // Load wins over enable, normalises, and masks tc.
        addVec(1'b1, 1'b1, 1'b1, 4'd7,  1'b0, 4'd6,  1'b0);
        addVec(1'b1, 1'b1, 1'b1, 4'd15, 1'b0, 4'd14, 1'b0);
        addVec(1'b1, 1'b1, 1'b1, 4'd14, 1'b0, 4'd14, 1'b0);
        addVec(1'b1, 1'b0, 1'b1, 4'd3,  1'b0, 4'd2,  1'b0);
        addVec(1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 4'd0,  1'b0);
        addVec(1'b1, 1'b0, 1'b1, 4'd1,  1'b0, 4'd0,  1'b0);
        // Direction toggling every cycle, then hold with en low.
        addVec(1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 4'd8,  1'b0);
        addVec(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd10, 1'b0);
        addVec(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd8,  1'b0);
        addVec(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd10, 1'b0);
        addVec(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd8,  1'b0);
        addVec(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd8,  1'b0);
        addVec(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd8,  1'b0);
        addVec(1'b0, 1'b1, 1'b1, 4'd14, 1'b0, 4'd14, 1'b0);
        addVec(1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd14, 1'b0);
        // Approach the top from 12, sit at the bound, then reverse.
        addVec(1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 4'd12, 1'b0);
        addVec(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd14, 1'b0);
        addVec(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, SAT ? 4'd14 : 4'd0, 1'b1);
        addVec(1'b1, 1'b1, 1'b0, 4'd0, SAT,  SAT ? 4'd14 : 4'd2, SAT);
        addVec(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, SAT ? 4'd12 : 4'd0, 1'b0);

        // Reset state, with en=1/up=0 so an ungated tc would read 1.
        @(negedge clock);
        @(negedge clock);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_wrap", 32'(wrap), 32'd0);
        checkOutput("reset_tc", 32'(tc), 32'd0);
        checkOutput("reset_count3", 32'(count3), 32'd3);
        reset = 1'b0;
        en = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Second instance: coarse step, offset range, top bound at 2**WIDTH-1.
        step3(1'b0, 1'b0, 1'b1, 4'd1,  1'b0, 4'd3,  1'b0, "s3_load1");
        step3(1'b0, 1'b0, 1'b1, 4'd11, 1'b0, 4'd9,  1'b0, "s3_load11");
        step3(1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 4'd15, 1'b0, "s3_load15");
        step3(1'b1, 1'b1, 1'b0, 4'd0,  1'b1, SAT ? 4'd15 : 4'd3, 1'b1, "s3_up_top");
        step3(1'b0, 1'b0, 1'b1, 4'd4,  1'b0, 4'd3,  1'b0, "s3_load4");
        step3(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, SAT ? 4'd3 : 4'd15, 1'b1, "s3_dn_bot");
        step3(1'b1, 1'b0, 1'b0, 4'd0,  SAT, SAT ? 4'd3 : 4'd12, SAT, "s3_dn_next");

        // Asynchronous reset mid-count: clears before the next edge, first edge after counts.
        applyStimulus('{1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 4'd4, 1'b0}, 100);
        applyStimulus('{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd6, 1'b0}, 101);
        up = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_count", 32'(count), 32'd0);
        checkOutput("midreset_wrap", 32'(wrap), 32'd0);
        checkOutput("midreset_tc", 32'(tc), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("midreset_hold", 32'(count), 32'd0);
        @(negedge clock);
        up = 1'b1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("postreset_count", 32'(count), 32'd2);
        checkOutput("postreset_wrap", 32'(wrap), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
